control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//   Queued, multi-cycle successor to the combinational instruction decoder. Buffers TPU
//   instructions in a FIFO and dispatches each one as timed control strobes.
//   Phases run in order: load_weights burst, load_inputs burst, then an nn_start pulse
//   and a wait for op_done.
//   Sits between the host/instruction source and the systolic array / activation datapath.
// PARAMETERS
//   ACT_W  2  width of activation-select field and activation_datapath output
//   LEN_W  4  burst-length field width; each load phase lasts len+1 cycles
//   DEPTH  4  instruction FIFO depth; power of two, >=2
//   (localparam INSTR_W = ACT_W+3+LEN_W)
// PORTS
//   clk                  in   1                 clock, all state on rising edge
//   rst                  in   1                 synchronous, active-high reset
//   instr_valid          in   1                 instruction offered
//   instr                in   INSTR_W           {len, load_weights, load_inputs, nn_start, act}, act in LSBs
//   instr_ready          out  1                 FIFO can accept (= !full)
//   activation_datapath  out  ACT_W             act field of last dispatched instruction, held
//   load_weights         out  1                 high during LOAD_W phase
//   load_inputs          out  1                 high during LOAD_I phase
//   nn_start             out  1                 one-cycle pulse on entry to RUN
//   op_done              in   1                 array finished; ends RUN
//   busy                 out  1                 (state!=IDLE) | (fifo_count!=0)
//   fifo_count           out  $clog2(DEPTH+1)   entries queued
//   perf_busy_cycles     out  32                only with CTRL_SEQ_PERF_EN
// BEHAVIOUR
//   Reset: FIFO emptied, state=IDLE, all outputs 0 except instr_ready=1. Applies mid-operation too;
//     an in-flight instruction is discarded.
//   Push: instr_valid & instr_ready at edge -> write tail. instr_ready = !full, even if a pop occurs in
//     the same cycle. No bypass: a pushed entry is dispatchable the cycle after the push at the earliest.
//   Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap mod DEPTH.
//   FSM states: IDLE, LOAD_W, LOAD_I, RUN.
//   IDLE with count!=0 -> dispatch (cycle D):
//     - Pop the head entry.
//     - activation_datapath <= act.
//     - Burst counter <= len.
//     - Next state = first set phase, in order W, I, RUN.
//     - No phase bit set (NOP): only act is updated; remain IDLE.
//   LOAD_W: load_weights=1. Decrement counter each cycle; at 0, reload counter with len and go to the
//     next set phase (LOAD_I, else RUN, else IDLE). Phase lasts exactly len+1 cycles.
//   LOAD_I: load_inputs=1 for len+1 cycles. Then go to RUN if nn_start is set, else IDLE.
//   RUN:
//     - nn_start=1 only in the first RUN cycle.
//     - op_done is ignored in that cycle.
//     - op_done=1 in any later RUN cycle -> IDLE next cycle.
//     - No timeout.
//   Strobes decode from registered state, so there are no combinational paths from inputs to strobes.
//     Strobes are mutually exclusive.
//   Back-to-back instructions: one IDLE (dispatch) cycle between consecutive instructions.
//   len is a LEN_W-bit unsigned field. len=0 gives a 1-cycle burst; max len = 2^LEN_W-1.
// CONFIGURATION
//   CTRL_SEQ_PERF_EN defined:
//     - Adds perf_busy_cycles.
//     - Increments each cycle busy=1 and saturates at 32'hFFFF_FFFF.
//     - Cleared only by rst.
//   Not defined: port and counter are absent. All other behaviour is identical.
// TESTING
//   1 rst held 2 cycles -> all strobes 0, activation_datapath=0, instr_ready=1, fifo_count=0, busy=0.
//   2 push {len=2,W=1,act=01} -> dispatch next cycle; load_weights high exactly 3 cycles;
//     activation_datapath=01; then busy=0.
//   3 push {len=0,W=1,I=1,S=1,act=10}:
//     - load_weights 1 cycle, then load_inputs 1 cycle, then nn_start 1 pulse.
//     - op_done in the pulse cycle is ignored.
//     - op_done raised 4 cycles later -> IDLE the next cycle.
//   4 DEPTH=4: hold RUN (no op_done) and push 5 -> instr_ready=0 after the 4th, fifo_count=4, 5th stalls.
//     Assert op_done -> 5th is accepted after the next pop.
//   5 NOP {act=11, bits 0} -> activation_datapath=11, no strobes, next queued instr dispatched the following cycle.
//   6 rst asserted mid LOAD_W with 2 queued -> cycle after: load_weights=0, fifo_count=0, state IDLE;
//     PERF build: perf_busy_cycles=0.

Source files
------------

// File: rtl/control_sequencer.sv
// Queued control sequencer: buffers TPU instructions in a FIFO and dispatches each as
// timed load_weights / load_inputs / nn_start strobes. Optional macro: CTRL_SEQ_PERF_EN.
module control_sequencer #(
  parameter int ACT_W = 2,
  parameter int LEN_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         instr_valid,
  input  logic [ACT_W+LEN_W+2:0]       instr,
  output logic                         instr_ready,
  output logic [ACT_W-1:0]             activation_datapath,
  output logic                         load_weights,
  output logic                         load_inputs,
  output logic                         nn_start,
  input  logic                         op_done,
  output logic                         busy,
`ifdef CTRL_SEQ_PERF_EN
  output logic [31:0]                  perf_busy_cycles,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int INSTR_W = ACT_W + 3 + LEN_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD_W, ST_LOAD_I, ST_RUN} state_t;

  state_t               state_r;
  logic [INSTR_W-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]     count_r, count_nxt_s;
  logic [LEN_W-1:0]     cnt_r, len_r;
  logic                 do_i_r, do_s_r;
  logic                 ready_r, lw_r, li_r, ns_r, busy_r;
  logic [ACT_W-1:0]     act_r;
  logic                 push_s, pop_s;
  logic [INSTR_W-1:0]   head_s;
  logic [LEN_W-1:0]     head_len_s;
  logic                 head_w_s, head_i_s, head_s_s;

  // Handshake decode and next FIFO occupancy; pops only from registered count, so no bypass.
  always_comb begin
    push_s      = instr_valid & ready_r;
    pop_s       = (state_r == ST_IDLE) && (count_r != {CNT_W{1'b0}});
    head_s      = mem_r[rd_ptr_r];
    head_len_s  = head_s[INSTR_W-1 -: LEN_W];
    head_w_s    = head_s[ACT_W+2];
    head_i_s    = head_s[ACT_W+1];
    head_s_s    = head_s[ACT_W];
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= instr;
    end
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      ready_r  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_nxt_s;
      ready_r <= (count_nxt_s != CNT_W'(DEPTH));
    end
  end

  // Dispatch FSM; strobes and busy are registered alongside each state transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {LEN_W{1'b0}};
      len_r   <= {LEN_W{1'b0}};
      do_i_r  <= 1'b0;
      do_s_r  <= 1'b0;
      act_r   <= {ACT_W{1'b0}};
      lw_r    <= 1'b0;
      li_r    <= 1'b0;
      ns_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      lw_r   <= 1'b0;
      li_r   <= 1'b0;
      ns_r   <= 1'b0;
      busy_r <= (count_nxt_s != {CNT_W{1'b0}});
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            act_r  <= head_s[ACT_W-1:0];
            cnt_r  <= head_len_s;
            len_r  <= head_len_s;
            do_i_r <= head_i_s;
            do_s_r <= head_s_s;
            if (head_w_s) begin
              state_r <= ST_LOAD_W; lw_r <= 1'b1; busy_r <= 1'b1;
            end else if (head_i_s) begin
              state_r <= ST_LOAD_I; li_r <= 1'b1; busy_r <= 1'b1;
            end else if (head_s_s) begin
              state_r <= ST_RUN; ns_r <= 1'b1; busy_r <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD_W: begin
          if (cnt_r == {LEN_W{1'b0}}) begin
            cnt_r <= len_r;
            if (do_i_r) begin
              state_r <= ST_LOAD_I; li_r <= 1'b1; busy_r <= 1'b1;
            end else if (do_s_r) begin
              state_r <= ST_RUN; ns_r <= 1'b1; busy_r <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            cnt_r <= cnt_r - LEN_W'(1); lw_r <= 1'b1; busy_r <= 1'b1;
          end
        end
        ST_LOAD_I: begin
          if (cnt_r == {LEN_W{1'b0}}) begin
            cnt_r <= len_r;
            if (do_s_r) begin
              state_r <= ST_RUN; ns_r <= 1'b1; busy_r <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            cnt_r <= cnt_r - LEN_W'(1); li_r <= 1'b1; busy_r <= 1'b1;
          end
        end
        ST_RUN: begin
          // The nn_start cycle ignores op_done.
          if (op_done && !ns_r) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_RUN; busy_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CTRL_SEQ_PERF_EN
  logic [31:0] perf_r;

  // Saturating count of busy cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_r <= 32'd0;
    end else if (busy_r && (perf_r != 32'hFFFF_FFFF)) begin
      perf_r <= perf_r + 32'd1;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign perf_busy_cycles = perf_r;
`endif

  assign instr_ready         = ready_r;
  assign activation_datapath = act_r;
  assign load_weights        = lw_r;
  assign load_inputs         = li_r;
  assign nn_start            = ns_r;
  assign busy                = busy_r;
  assign fifo_count          = count_r;

endmodule
